// File: rtl/eae_mul_sequencer_if.sv
// Bus between the EAE control unit, the MUY sequencer and the shift-add multiplier.
// Carries the command handshake, the latched operands to the multiplier and the results.
// slave = sequencer side, master = control unit / multiplier side.
`timescale 1ns/1ps
interface eae_mul_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] mq_in;
  logic [11:0] operand;
  logic        mul_start;
  logic [11:0] mul_multiplier;
  logic [11:0] mul_multiplicand;
  logic [23:0] mul_product;
  logic        mul_finished;
  logic [11:0] ac_out;
  logic [11:0] mq_out;
  logic        link_clr;
  logic        done;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  cmd_valid, mq_in, operand, mul_product, mul_finished,
    output cmd_ready, mul_start, mul_multiplier, mul_multiplicand,
           ac_out, mq_out, link_clr, done, busy, timeout_err
  );

  modport master (
    output cmd_valid, mq_in, operand, mul_product, mul_finished,
    input  cmd_ready, mul_start, mul_multiplier, mul_multiplicand,
           ac_out, mq_out, link_clr, done, busy, timeout_err
  );
endinterface

// File: rtl/eae_mul_sequencer.sv
// EAE MUY issue sequencer: latches MQ/operand, pulses start, writes product to AC/MQ.
// Latency: accept edge E0 -> start in E0+1 -> done in E0+15 (nominal), ready again E0+16.
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is dropped, not queued.
`timescale 1ns/1ps
module eae_mul_sequencer #(
  parameter int FLUSH_CYCLES = 4,
  parameter int MUL_TIMEOUT  = 31
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  eae_mul_sequencer_if.slave io_mul
);

  localparam int CNT_MAX = (MUL_TIMEOUT > FLUSH_CYCLES) ? MUL_TIMEOUT : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  // START is the first counted cycle and ERR follows the last WAIT cycle, so
  // WAIT gives up after MUL_TIMEOUT-1 cycles and ERR lands MUL_TIMEOUT after START.
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MUL_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [11:0]      r_multiplier;
  logic [11:0]      r_multiplicand;
  logic [11:0]      r_ac;
  logic [11:0]      r_mq;
  logic             w_accept;
  logic             w_capture;
  logic             w_cmd_ready;
  logic             w_mul_start;
  logic             w_busy;
  logic             w_done;
  logic             w_link_clr;
  logic             w_timeout_err;

  assign w_accept  = (r_state == S_IDLE) && io_mul.cmd_valid;
  assign w_capture = (r_state == S_WAIT) && io_mul.mul_finished;

  // State register; reset drops any pending command and restarts the flush.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_FLUSH;
    else            r_state <= w_state_next;
  end

  // Shared flush/wait counter: restarts on every state change, runs in FLUSH and WAIT.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)                      r_cnt <= '0;
    else if (w_state_next != r_state)    r_cnt <= '0;
    else if (r_state == S_FLUSH || r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
  end

  // Operand latches, held stable to the multiplier from accept until done.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_multiplier   <= '0;
      r_multiplicand <= '0;
    end else if (w_accept) begin
      r_multiplier   <= io_mul.operand;
      r_multiplicand <= io_mul.mq_in;
    end
  end

  // Result registers load on the finished cycle so they are valid alongside done; a timeout leaves them alone.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ac <= '0;
      r_mq <= '0;
    end else if (w_capture) begin
      r_ac <= io_mul.mul_product[23:12];
      r_mq <= io_mul.mul_product[11:0];
    end
  end

  // Next-state and Moore outputs; start is high only in START so it can never overlap finished.
  always_comb begin
    w_state_next  = r_state;
    w_cmd_ready   = 1'b0;
    w_mul_start   = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_link_clr    = 1'b0;
    w_timeout_err = 1'b0;
    case (r_state)
      S_FLUSH: begin
        if (r_cnt == FLUSH_LAST) w_state_next = S_IDLE;
      end
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (io_mul.cmd_valid) w_state_next = S_START;
      end
      S_START: begin
        w_mul_start  = 1'b1;
        w_busy       = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (io_mul.mul_finished)    w_state_next = S_WRITE;
        else if (r_cnt == WAIT_LAST) w_state_next = S_ERR;
      end
      S_WRITE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_link_clr   = 1'b1;
        w_state_next = S_IDLE;
      end
      S_ERR: begin
        w_busy        = 1'b1;
        w_done        = 1'b1;
        w_timeout_err = 1'b1;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_FLUSH;
    endcase
  end

  assign io_mul.cmd_ready        = w_cmd_ready;
  assign io_mul.mul_start        = w_mul_start;
  assign io_mul.mul_multiplier   = r_multiplier;
  assign io_mul.mul_multiplicand = r_multiplicand;
  assign io_mul.ac_out           = r_ac;
  assign io_mul.mq_out           = r_mq;
  assign io_mul.link_clr         = w_link_clr;
  assign io_mul.done             = w_done;
  assign io_mul.busy             = w_busy;
  assign io_mul.timeout_err      = w_timeout_err;

endmodule

// File: tb/tb_eae_mul_sequencer.sv
// Bench for eae_mul_sequencer: fixed vector table, hand-written multi-cycle sequences,
// and a random run against a plain-arithmetic product model.
// A behavioural 12-step multiplier stub answers start pulses (can be muted for timeouts).
`timescale 1ns/1ps
module tb_eae_mul_sequencer;
  localparam int FLUSH_CYCLES = 4;
  localparam int MUL_TIMEOUT  = 31;
  localparam int NOMINAL_DONE = 15;  // done cycle relative to the accept edge

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  eae_mul_sequencer_if bus();

  eae_mul_sequencer #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .MUL_TIMEOUT  (MUL_TIMEOUT)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io_mul    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] last_ac = '0;
  logic [11:0] last_mq = '0;

  // Multiplier stub: start sampled mid-cycle; finished is present at the edge that
  // closes the 13th cycle after the START cycle (E0+14), as a 12-step multiplier would.
  bit          stub_en   = 1'b1;
  logic        stub_fin  = 1'b0;
  logic        spur      = 1'b0;
  logic [23:0] stub_prod = '0;
  int          stub_cnt  = 0;
  logic [11:0] stub_a    = '0;
  logic [11:0] stub_b    = '0;

  assign bus.mul_finished = stub_fin | spur;
  assign bus.mul_product  = stub_prod;

  always @(negedge clk) begin
    stub_fin = 1'b0;
    if (stub_en && bus.mul_start === 1'b1) begin
      stub_cnt = 13;
      stub_a   = bus.mul_multiplicand;
      stub_b   = bus.mul_multiplier;
    end else if (stub_cnt != 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        stub_fin  = 1'b1;
        stub_prod = 24'(stub_a) * 24'(stub_b);
      end
    end
  end

  typedef struct packed {
    logic [11:0] mq;
    logic [11:0] op;
    logic [11:0] ac_exp;
    logic [11:0] mq_exp;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [23:0] mul_ref(input logic [11:0] a, input logic [11:0] b);
    return 24'(a) * 24'(b);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_zero();
    chk("rst_ctrl_outputs", {26'd0, bus.cmd_ready, bus.mul_start, bus.busy,
                             bus.done, bus.link_clr, bus.timeout_err}, 32'd0);
    chk("rst_ac_mq", {8'd0, bus.ac_out, bus.mq_out}, 32'd0);
    chk("rst_latches", {8'd0, bus.mul_multiplier, bus.mul_multiplicand}, 32'd0);
  endtask

  // Assert reset, check outputs clear at once, release, then time the flush.
  task automatic reset_and_flush();
    int  n;
    bit  done_seen;
    rst_n = 1'b0;
    #1;
    check_zero();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    last_ac   = '0;
    last_mq   = '0;
    n         = 0;
    done_seen = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) done_seen = 1'b1;
      if (bus.cmd_ready === 1'b1) break;
    end
    chk("flush_cycles", n, FLUSH_CYCLES);
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    chk("no_done_after_reset", {31'd0, done_seen}, 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_reached", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  // One command; expectations come from the arithmetic model and the latency rules.
  task automatic run_cmd(input logic [11:0] mq, input logic [11:0] op, input bit to);
    logic [23:0] p;
    logic [11:0] eac, emq, got_ac, got_mq;
    logic        got_link, got_to, got_busy;
    int          exp_k, starts, start_k, done_k;
    p      = mul_ref(mq, op);
    eac    = to ? last_ac : p[23:12];
    emq    = to ? last_mq : p[11:0];
    exp_k  = to ? (MUL_TIMEOUT + 1) : NOMINAL_DONE;
    starts = 0; start_k = 0; done_k = 0;
    got_ac = '0; got_mq = '0; got_link = 1'b0; got_to = 1'b0; got_busy = 1'b0;
    wait_ready();
    bus.mq_in     = mq;
    bus.operand   = op;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.mq_in     = 12'($urandom);
    bus.operand   = 12'($urandom);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.mul_start === 1'b1) begin
        starts++;
        start_k = k;
      end
      if (k == 1) begin
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        chk("latched_multiplier", {20'd0, bus.mul_multiplier}, {20'd0, op});
        chk("latched_multiplicand", {20'd0, bus.mul_multiplicand}, {20'd0, mq});
      end
      if (bus.done === 1'b1) begin
        done_k   = k;
        got_ac   = bus.ac_out;
        got_mq   = bus.mq_out;
        got_link = bus.link_clr;
        got_to   = bus.timeout_err;
        got_busy = bus.busy;
        break;
      end
    end
    chk("done_cycle", done_k, exp_k);
    chk("start_pulse_count", starts, 1);
    chk("start_cycle", start_k, 1);
    chk("ac_out", {20'd0, got_ac}, {20'd0, eac});
    chk("mq_out", {20'd0, got_mq}, {20'd0, emq});
    chk("link_clr", {31'd0, got_link}, {31'd0, !to});
    chk("timeout_err", {31'd0, got_to}, {31'd0, to});
    chk("busy_at_done", {31'd0, got_busy}, 32'd1);
    @(negedge clk);
    chk("ready_after_done", {31'd0, bus.cmd_ready}, 32'd1);
    chk("done_single_cycle", {31'd0, bus.done}, 32'd0);
    if (!to) begin
      last_ac = eac;
      last_mq = emq;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin : main
    logic [11:0] a, b, c, d;
    logic [23:0] pab, pcd;
    int          start_at [2];
    int          done_at  [2];
    logic [23:0] res      [2];
    int          nstart, ndone;
    bit          done_seen;

    bus.cmd_valid = 1'b0;
    bus.mq_in     = '0;
    bus.operand   = '0;

    vecs[0] = '{12'o0005, 12'o0003, 12'o0000, 12'o0017};
    vecs[1] = '{12'o7777, 12'o7777, 12'o7776, 12'o0001};
    vecs[2] = '{12'o0000, 12'o0000, 12'o0000, 12'o0000};
    vecs[3] = '{12'o4000, 12'o0002, 12'o0001, 12'o0000};
    vecs[4] = '{12'o1234, 12'o0010, 12'h001,  12'h4E0};
    vecs[5] = '{12'o0001, 12'o7777, 12'o0000, 12'o7777};

    // Power-on reset and flush timing.
    #3;
    reset_and_flush();

    // Fixed vector table (expected words written out by hand).
    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].mq, vecs[i].op, 1'b0);
      chk("vec_ac_table", {20'd0, last_ac}, {20'd0, vecs[i].ac_exp});
      chk("vec_mq_table", {20'd0, last_mq}, {20'd0, vecs[i].mq_exp});
    end

    // cmd_valid held through two commands; inputs change mid-operation.
    wait_ready();
    a = 12'o0123; b = 12'o0045; c = 12'o7000; d = 12'o0011;
    pab = mul_ref(a, b);
    pcd = mul_ref(c, d);
    bus.mq_in = a; bus.operand = b; bus.cmd_valid = 1'b1;
    @(posedge clk);
    nstart = 0; ndone = 0;
    start_at[0] = 0; start_at[1] = 0; done_at[0] = 0; done_at[1] = 0;
    res[0] = '0; res[1] = '0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 3) begin
        bus.mq_in   = c;
        bus.operand = d;
      end
      if (k == 15) chk("ready_closed_at_done", {31'd0, bus.cmd_ready}, 32'd0);
      if (k == 16) chk("ready_reopens_e16", {31'd0, bus.cmd_ready}, 32'd1);
      if (bus.mul_start === 1'b1) begin
        if (nstart < 2) start_at[nstart] = k;
        nstart++;
      end
      if (bus.done === 1'b1) begin
        if (ndone < 2) begin
          done_at[ndone] = k;
          res[ndone]     = {bus.ac_out, bus.mq_out};
        end
        ndone++;
      end
      if (k == 17) bus.cmd_valid = 1'b0;
      if (ndone == 2) break;
    end
    chk("held_valid_starts", nstart, 2);
    chk("held_valid_start0", start_at[0], 1);
    chk("held_valid_start1", start_at[1], 17);
    chk("held_valid_done0", done_at[0], 15);
    chk("held_valid_done1", done_at[1], 31);
    chk("held_valid_prod0", {8'd0, res[0]}, {8'd0, pab});
    chk("held_valid_prod1", {8'd0, res[1]}, {8'd0, pcd});
    last_ac = pcd[23:12];
    last_mq = pcd[11:0];

    // Multiplier never finishes: timeout, results untouched, then recovery.
    stub_en = 1'b0;
    run_cmd(12'o0707, 12'o0070, 1'b1);
    stub_en = 1'b1;
    run_cmd(12'o0707, 12'o0070, 1'b0);

    // Reset in the middle of an operation.
    wait_ready();
    bus.mq_in = 12'o3333; bus.operand = 12'o0444; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy_before_reset", {31'd0, bus.busy}, 32'd1);
    reset_and_flush();
    run_cmd(12'o3333, 12'o0444, 1'b0);

    // Spurious finished while IDLE.
    wait_ready();
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    done_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    chk("spurious_no_done", {31'd0, done_seen}, 32'd0);
    chk("spurious_ac_hold", {20'd0, bus.ac_out}, {20'd0, last_ac});
    chk("spurious_mq_hold", {20'd0, bus.mq_out}, {20'd0, last_mq});

    // Random commands against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      run_cmd(12'($urandom), 12'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
